video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator: HS/VS/DE plus active-pixel X/Y for the plane
//  pipeline, driven by the pixel clock and advanced only on the pixel-latch enable.
//  Holds a compile-time table of NUM_MODES video modes and switches modes glitch-free
//  at frame boundaries. Sits between the clock generator and the video/foreground planes.
// PARAMETERS
//  CW            12  width of the H/V counters and of every timing field
//  NUM_MODES     3   entries used from vtg_pkg mode table (0:800x600 1:1024x768 2:1280x720)
//  DEFAULT_MODE  2   mode loaded at reset
// PORTS
//  I_pxl_clk     in   1              pixel clock, sole clock
//  I_rst         in   1              synchronous reset, active-high
//  I_ce          in   1              pixel-latch enable; timing advances one pixel per high cycle
//  I_mode_req    in   1              1-cycle request to change mode
//  I_mode_sel    in   $clog2(NUM_MODES)  requested mode, sampled with I_mode_req
//  O_de          out  1              active video
//  O_hs          out  1              horizontal sync, polarity from mode table
//  O_vs          out  1              vertical sync, polarity from mode table
//  O_x           out  CW             active pixel column (0 outside DE)
//  O_y           out  CW             active line (0 outside DE)
//  O_frame_start out  1              1 for the ce-step showing h=0,v=0
//  O_mode_active out  $clog2(NUM_MODES)  mode currently being generated
//  O_mode_err    out  1              1-cycle pulse: request with I_mode_sel >= NUM_MODES
// BEHAVIOUR
//  - Reset (sync, I_rst=1 at posedge): h=v=0, mode=DEFAULT_MODE, pending cleared; O_de=0,
//    O_hs/O_vs = inactive level (~pol), O_x=O_y=0, O_frame_start=0, O_mode_err=0. Wins over I_ce.
//  - Counters: on I_ce, h+=1; h==h_total-1 -> h=0, v+=1; v==v_total-1 at h wrap -> v=0. I_ce=0 holds all.
//  - Decode, per counter value (h,v): HS active when h<h_sync; VS active when v<v_sync;
//    DE when h in [h_sync+h_bporch, +h_res) and v in [v_sync+v_bporch, +v_res);
//    X = h-(h_sync+h_bporch), Y = v-(v_sync+v_bporch) when DE, else 0.
//  - Latency: all outputs registered, updated only on I_ce cycles; outputs after I_ce edge k
//    describe the counter value held before edge k. Outputs stable while I_ce=0.
//  - Mode request: I_mode_req=1 with valid sel -> pending<=sel (latest request wins).
//    Invalid sel -> ignored, O_mode_err=1 next cycle, existing pending kept.
//  - Mode apply: on the I_ce edge where (h,v)=(h_total-1,v_total-1) and pending valid,
//    mode<=pending, pending cleared; new mode's frame starts at (0,0). Request arriving on that
//    same edge is not applied until the following frame wrap. No mid-frame timing change ever.
//  - Arithmetic: all comparisons unsigned CW-bit; table values must satisfy
//    sync+bporch+res <= total <= 2**CW-1 (checked by package assertion, not in RTL).
// CONFIGURATION
//  VTG_FRAME_COUNT_EN defined: adds port O_frame_cnt out 16, cleared on reset, +1 on each frame
//    wrap edge, wraps 16'hFFFF->0; mode switches do not clear it.
//  Not defined: port absent, no counter logic.
// STRUCTURE
//  vtg_pkg: mode record (h_total,h_sync,h_bporch,h_res,v_total,v_sync,v_bporch,v_res,
//    hs_pol,vs_pol), MODE_TABLE constant, mode index widths.
//  One sub-module: vtg_axis_cnt (generic wrap counter + sync/active window decode), instanced H and V.
// TESTING
//  1 Reset mid-frame, I_ce=1 -> next cycle O_de=0, O_hs=O_vs=0 (pol=1), O_x=O_y=0, mode=2.
//  2 Mode 2, I_ce=1 always -> per line HS high 40 ce, DE high 1280 ce starting h=260; 1650 ce/line,
//    VS high 5 lines, 720 DE lines, O_frame_start every 1237500 ce; X runs 0..1279.
//  3 I_ce=1 every 5th cycle -> same sequence as 2 at 1/5 rate, outputs frozen between enables.
//  4 Request sel=0 at v=100 -> mode 2 finishes frame, next frame 1056x628 timing, O_mode_active=0.
//  5 Requests sel=0 then sel=1 in same frame -> only mode 1 applied; sel=3 -> O_mode_err pulse, no change.
//  6 VTG_FRAME_COUNT_EN: 3 frames after reset -> O_frame_cnt=3; preload near wrap -> 16'hFFFF->0.

Source files
------------

// File: rtl/vtg_pkg.sv
// vtg_pkg: video mode record, compile-time mode table and a table sanity helper
// shared by video_timing_gen and its axis counter.
// The optional frame counter in video_timing_gen is enabled by VTG_FRAME_COUNT_EN.
package vtg_pkg;

    localparam int VTG_CW        = 12;
    localparam int VTG_TABLE_LEN = 3;
    localparam int VTG_IW        = $clog2(VTG_TABLE_LEN);

    typedef struct packed {
        logic [VTG_CW-1:0] h_total;
        logic [VTG_CW-1:0] h_sync;
        logic [VTG_CW-1:0] h_bporch;
        logic [VTG_CW-1:0] h_res;
        logic [VTG_CW-1:0] v_total;
        logic [VTG_CW-1:0] v_sync;
        logic [VTG_CW-1:0] v_bporch;
        logic [VTG_CW-1:0] v_res;
        logic              hs_pol;
        logic              vs_pol;
    } mode_t;

    typedef mode_t [VTG_TABLE_LEN-1:0] mode_table_t;

    // Entry 0: 800x600, entry 1: 1024x768, entry 2: 1280x720
    localparam mode_table_t MODE_TABLE = {
        mode_t'{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1},
        mode_t'{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0},
        mode_t'{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1}
    };

    // True when every used entry fits its sync, back porch and active region inside the total
    function automatic bit mode_table_ok(input mode_table_t t, input int n);
        bit ok;
        ok = (n >= 1) && (n <= VTG_TABLE_LEN);
        for (int i = 0; i < VTG_TABLE_LEN; i++) begin
            if (i < n) begin
                if (int'(t[i[VTG_IW-1:0]].h_sync) + int'(t[i[VTG_IW-1:0]].h_bporch) +
                    int'(t[i[VTG_IW-1:0]].h_res) > int'(t[i[VTG_IW-1:0]].h_total))
                    ok = 1'b0;
                if (int'(t[i[VTG_IW-1:0]].v_sync) + int'(t[i[VTG_IW-1:0]].v_bporch) +
                    int'(t[i[VTG_IW-1:0]].v_res) > int'(t[i[VTG_IW-1:0]].v_total))
                    ok = 1'b0;
                if (t[i[VTG_IW-1:0]].h_total == '0 || t[i[VTG_IW-1:0]].v_total == '0)
                    ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/vtg_axis_cnt.sv
// vtg_axis_cnt: one raster axis. Wrapping position counter plus combinational
// decode of the sync window, the active window and the offset inside it.
module vtg_axis_cnt #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [CW-1:0] total,
    input  logic [CW-1:0] sync,
    input  logic [CW-1:0] bporch,
    input  logic [CW-1:0] res,
    output logic [CW-1:0] cnt,
    output logic          last,
    output logic          sync_on,
    output logic          act,
    output logic [CW-1:0] act_pos
);

    logic [CW-1:0] start;

    // Window decode of the current counter value
    always_comb begin
        start   = sync + bporch;
        last    = (cnt == total - 1'b1);
        sync_on = (cnt < sync);
        act     = (cnt >= start) && (cnt < start + res);
        act_pos = cnt - start;
    end

    // Advance one position per step, wrapping after total-1
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (step)
            cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (HS/VS/DE, active X/Y, frame start)
// with a compile-time mode table and mode changes deferred to the frame wrap.
// Define VTG_FRAME_COUNT_EN to add the 16-bit O_frame_cnt output.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int          CW           = VTG_CW,
    parameter int          NUM_MODES    = 3,
    parameter int          DEFAULT_MODE = 2,
    parameter mode_table_t MODES        = MODE_TABLE,
    localparam int         MW           = $clog2(NUM_MODES)
) (
    input  logic          I_pxl_clk,
    input  logic          I_rst,
    input  logic          I_ce,
    input  logic          I_mode_req,
    input  logic [MW-1:0] I_mode_sel,
    output logic          O_de,
    output logic          O_hs,
    output logic          O_vs,
    output logic [CW-1:0] O_x,
    output logic [CW-1:0] O_y,
    output logic          O_frame_start,
    output logic [MW-1:0] O_mode_active,
    output logic          O_mode_err
`ifdef VTG_FRAME_COUNT_EN
    ,
    output logic [15:0]   O_frame_cnt
`endif
);

    if (!mode_table_ok(MODES, NUM_MODES)) begin : g_bad_table
        $error("video_timing_gen: mode table entry exceeds its total");
    end

    mode_t         cur;
    logic [MW-1:0] pend;
    logic          pend_vld;
    logic          sel_ok;
    logic          frame_wrap;
    logic          de_next;

    logic [CW-1:0] h_cnt, v_cnt, h_pos, v_pos;
    logic          h_last, v_last, h_sync_on, v_sync_on, h_act, v_act;

    assign cur        = MODES[O_mode_active];
    assign sel_ok     = 32'(I_mode_sel) < NUM_MODES;
    assign frame_wrap = I_ce && h_last && v_last;
    assign de_next    = h_act && v_act;

    vtg_axis_cnt #(.CW(CW)) u_h (
        .clk     (I_pxl_clk),
        .rst     (I_rst),
        .step    (I_ce),
        .total   (CW'(cur.h_total)),
        .sync    (CW'(cur.h_sync)),
        .bporch  (CW'(cur.h_bporch)),
        .res     (CW'(cur.h_res)),
        .cnt     (h_cnt),
        .last    (h_last),
        .sync_on (h_sync_on),
        .act     (h_act),
        .act_pos (h_pos)
    );

    vtg_axis_cnt #(.CW(CW)) u_v (
        .clk     (I_pxl_clk),
        .rst     (I_rst),
        .step    (I_ce && h_last),
        .total   (CW'(cur.v_total)),
        .sync    (CW'(cur.v_sync)),
        .bporch  (CW'(cur.v_bporch)),
        .res     (CW'(cur.v_res)),
        .cnt     (v_cnt),
        .last    (v_last),
        .sync_on (v_sync_on),
        .act     (v_act),
        .act_pos (v_pos)
    );

    // Mode request capture and frame-boundary apply; a request on the wrap edge stays pending
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            O_mode_active <= MW'(DEFAULT_MODE);
            pend          <= '0;
            pend_vld      <= 1'b0;
            O_mode_err    <= 1'b0;
        end else begin
            O_mode_err <= I_mode_req && !sel_ok;
            if (frame_wrap && pend_vld) begin
                O_mode_active <= pend;
                pend_vld      <= 1'b0;
            end
            if (I_mode_req && sel_ok) begin
                pend     <= I_mode_sel;
                pend_vld <= 1'b1;
            end
        end
    end

    // Registered raster outputs describing the counter value held before this enable
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            O_de          <= 1'b0;
            O_hs          <= ~MODES[DEFAULT_MODE].hs_pol;
            O_vs          <= ~MODES[DEFAULT_MODE].vs_pol;
            O_x           <= '0;
            O_y           <= '0;
            O_frame_start <= 1'b0;
        end else if (I_ce) begin
            O_de          <= de_next;
            O_hs          <= h_sync_on ? cur.hs_pol : ~cur.hs_pol;
            O_vs          <= v_sync_on ? cur.vs_pol : ~cur.vs_pol;
            O_x           <= de_next ? h_pos : '0;
            O_y           <= de_next ? v_pos : '0;
            O_frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VTG_FRAME_COUNT_EN
    // Frames completed since reset, wrapping at 16 bits; untouched by mode switches
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst)
            O_frame_cnt <= '0;
        else if (frame_wrap)
            O_frame_cnt <= O_frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: two generators on one clock, one with the production mode
// table and one with a tiny table so that frame wraps and mode switches occur
// often. A linear pixel-index reference model predicts every cycle's outputs;
// predictions are queued at each edge and a negedge monitor compares them.
module tb_video_timing_gen;
    import vtg_pkg::*;

    // Tiny modes for the second instance (entry 0, 1, 2)
    localparam mode_table_t SMALL = {
        mode_t'{12'd9,  12'd3, 12'd1, 12'd4, 12'd7, 12'd1, 12'd2, 12'd3, 1'b1, 1'b1},
        mode_t'{12'd10, 12'd1, 12'd1, 12'd7, 12'd6, 12'd2, 12'd1, 12'd3, 1'b0, 1'b1},
        mode_t'{12'd12, 12'd2, 12'd2, 12'd6, 12'd8, 12'd1, 12'd1, 12'd5, 1'b1, 1'b0}
    };

    // Reference timing, [instance][mode]
    localparam int HT[2][3] = '{'{1056, 1344, 1650}, '{12, 10, 9}};
    localparam int HS[2][3] = '{'{128, 136, 40},     '{2, 1, 3}};
    localparam int HB[2][3] = '{'{88, 160, 220},     '{2, 1, 1}};
    localparam int HR[2][3] = '{'{800, 1024, 1280},  '{6, 7, 4}};
    localparam int VT[2][3] = '{'{628, 806, 750},    '{8, 6, 7}};
    localparam int VS[2][3] = '{'{4, 6, 5},          '{1, 2, 1}};
    localparam int VB[2][3] = '{'{23, 29, 20},       '{1, 1, 2}};
    localparam int VR[2][3] = '{'{600, 768, 720},    '{5, 3, 3}};
    localparam bit HP[2][3] = '{'{1, 0, 1},          '{1, 0, 1}};
    localparam bit VP[2][3] = '{'{1, 0, 1},          '{0, 1, 1}};
    localparam int DEF = 2;

    typedef struct {
        bit de, hs, vs, fs, err;
        int x, y, ma, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1, ce = 1'b1, req = 1'b0;
    logic [1:0] sel = 2'd0;

    logic a_de, a_hs, a_vs, a_fs, a_err, b_de, b_hs, b_vs, b_fs, b_err;
    logic [11:0] a_x, a_y, b_x, b_y;
    logic [1:0]  a_ma, b_ma;
`ifdef VTG_FRAME_COUNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int xmax    = 0;

    exp_t q0[$], q1[$];
    int   pos[2], mode[2], pend[2], fc[2];
    bit   pv[2];
    exp_t last_e[2];

    always #5 clk = ~clk;

    video_timing_gen dut_a (
        .I_pxl_clk(clk), .I_rst(rst), .I_ce(ce), .I_mode_req(req), .I_mode_sel(sel),
        .O_de(a_de), .O_hs(a_hs), .O_vs(a_vs), .O_x(a_x), .O_y(a_y),
        .O_frame_start(a_fs), .O_mode_active(a_ma), .O_mode_err(a_err)
`ifdef VTG_FRAME_COUNT_EN
        , .O_frame_cnt(a_fc)
`endif
    );

    video_timing_gen #(.MODES(SMALL)) dut_b (
        .I_pxl_clk(clk), .I_rst(rst), .I_ce(ce), .I_mode_req(req), .I_mode_sel(sel),
        .O_de(b_de), .O_hs(b_hs), .O_vs(b_vs), .O_x(b_x), .O_y(b_y),
        .O_frame_start(b_fs), .O_mode_active(b_ma), .O_mode_err(b_err)
`ifdef VTG_FRAME_COUNT_EN
        , .O_frame_cnt(b_fc)
`endif
    );

    // Reference: frame position as one linear pixel index, decoded with div/mod
    function automatic exp_t model_step(input int d, input bit r, input bit c,
                                        input bit rq, input int s);
        exp_t e;
        int m, h, v, xs, ys;
        e = last_e[d];
        if (r) begin
            pos[d] = 0; mode[d] = DEF; pv[d] = 0; fc[d] = 0;
            e.de = 0; e.hs = !HP[d][DEF]; e.vs = !VP[d][DEF];
            e.x = 0; e.y = 0; e.fs = 0; e.err = 0;
        end else begin
            e.err = rq && (s >= 3);
            if (c) begin
                m  = mode[d];
                h  = pos[d] % HT[d][m];
                v  = pos[d] / HT[d][m];
                xs = HS[d][m] + HB[d][m];
                ys = VS[d][m] + VB[d][m];
                e.hs = (h < HS[d][m]) ? HP[d][m] : !HP[d][m];
                e.vs = (v < VS[d][m]) ? VP[d][m] : !VP[d][m];
                e.de = (h >= xs) && (h < xs + HR[d][m]) && (v >= ys) && (v < ys + VR[d][m]);
                e.x  = e.de ? h - xs : 0;
                e.y  = e.de ? v - ys : 0;
                e.fs = (pos[d] == 0);
                if (pos[d] == HT[d][m] * VT[d][m] - 1) begin
                    pos[d] = 0;
                    fc[d]  = (fc[d] + 1) % 65536;
                    if (pv[d]) begin
                        mode[d] = pend[d];
                        pv[d]   = 0;
                    end
                end else begin
                    pos[d] = pos[d] + 1;
                end
            end
            if (rq && s < 3) begin
                pend[d] = s;
                pv[d]   = 1;
            end
        end
        e.ma = mode[d];
        e.fc = fc[d];
        last_e[d] = e;
        return e;
    endfunction

    // Predict the outcome of the edge just taken, using the inputs that were applied to it
    task automatic tick();
        @(posedge clk);
        #1;
        q0.push_back(model_step(0, rst, ce, req, int'(sel)));
        q1.push_back(model_step(1, rst, ce, req, int'(sel)));
    endtask

    task automatic check(input int d, input exp_t e, input exp_t a);
        bit ok;
        n_tests++;
        ok = (a.de == e.de) && (a.hs == e.hs) && (a.vs == e.vs) && (a.x == e.x) &&
             (a.y == e.y) && (a.fs == e.fs) && (a.ma == e.ma) && (a.err == e.err);
`ifdef VTG_FRAME_COUNT_EN
        ok = ok && (a.fc == e.fc);
`endif
        if (!ok) begin
            n_fail++;
            $display("FAIL raster dut%0d t=%0t: got de%0b hs%0b vs%0b x%0d y%0d fs%0b mode%0d err%0b fc%0d, want de%0b hs%0b vs%0b x%0d y%0d fs%0b mode%0d err%0b fc%0d",
                     d, $time, a.de, a.hs, a.vs, a.x, a.y, a.fs, a.ma, a.err, a.fc,
                     e.de, e.hs, e.vs, e.x, e.y, e.fs, e.ma, e.err, e.fc);
        end
    endtask

    // Monitor: pop one prediction per instance each cycle and compare
    always @(negedge clk) begin
        exp_t e, a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a.de = a_de; a.hs = a_hs; a.vs = a_vs; a.fs = a_fs; a.err = a_err;
            a.x = int'(a_x); a.y = int'(a_y); a.ma = int'(a_ma); a.fc = 0;
`ifdef VTG_FRAME_COUNT_EN
            a.fc = int'(a_fc);
`endif
            check(0, e, a);
            if (a_de && int'(a_x) > xmax) xmax = int'(a_x);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a.de = b_de; a.hs = b_hs; a.vs = b_vs; a.fs = b_fs; a.err = b_err;
            a.x = int'(b_x); a.y = int'(b_y); a.ma = int'(b_ma); a.fc = 0;
`ifdef VTG_FRAME_COUNT_EN
            a.fc = int'(b_fc);
`endif
            check(1, e, a);
        end
    end

    initial begin
        // Reset, free run, then reset again mid-frame while enabled
        rst = 1'b1; ce = 1'b1; req = 1'b0; sel = 2'd0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Continuous enable long enough to cover full active lines of the 1280x720 mode;
        // requests sel=0, then sel=1, then an invalid sel=3
        for (int i = 0; i < 45000; i++) begin
            req = (i == 20000) || (i == 20500) || (i == 21000);
            sel = (i == 20000) ? 2'd0 : (i == 20500) ? 2'd1 : 2'd3;
            tick();
        end
        req = 1'b0;

        // Enable every fifth cycle; outputs must hold in between
        for (int i = 0; i < 5000; i++) begin
            ce = (i % 5 == 0);
            tick();
        end

        // Random enable, requests (valid and invalid) and rare resets
        for (int i = 0; i < 20000; i++) begin
            rst = ($urandom_range(0, 4999) == 0);
            ce  = ($urandom_range(0, 3) != 0);
            req = ($urandom_range(0, 29) == 0);
            sel = 2'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0; ce = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);

        n_tests++;
        if (xmax != 1279) begin
            n_fail++;
            $display("FAIL x_span: largest active X seen %0d, want 1279", xmax);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
